// File: rtl/wav_sample_mixer.sv
// Multi-channel wave ROM sample player: one arbitrated ROM port, per-channel volume,
// scaled sum saturated to a signed output at a programmable sample rate.
//
// state | meaning
// IDLE  | waiting for a sample-rate tick
// SCAN  | visit channel ch; fetch its sample from ROM when active
// MAC   | accumulate data*vol, advance ch pointer/remaining count
// OUT   | saturate accumulator to O_SND, pulse O_SAMPLE_TICK
module wav_sample_mixer #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 16,
  parameter int DIV_W    = 12,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic [DIV_W-1:0]  I_DIV,
  input  logic              I_CMD_VALID,
  input  logic [CH_W-1:0]   I_CMD_CHAN,
  input  logic              I_CMD_OP,
  input  logic [ADDR_W-1:0] I_CMD_ADDR,
  input  logic [LEN_W-1:0]  I_CMD_LEN,
  input  logic [7:0]        I_CMD_VOL,
  input  logic              I_CMD_LOOP,
  output logic              O_ROM_REQ,
  output logic [ADDR_W-1:0] O_ROM_ADDR,
  input  logic              I_ROM_ACK,
  input  logic [DATA_W-1:0] I_ROM_DATA,
  output logic [DATA_W-1:0] O_SND,
  output logic [CHANNELS-1:0] O_ACTIVE,
  output logic              O_SAMPLE_TICK,
  output logic              O_OVERRUN
);

  localparam int ACC_W = DATA_W + 9 + CH_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MAC, S_OUT} state_t;

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic                      last_ch;
  logic [DIV_W-1:0]          div_cnt;
  logic [DIV_W-1:0]          div_lim;
  logic                      tick;
  logic signed [DATA_W-1:0]  data_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [DATA_W+8:0]  prod;
  logic [DATA_W-1:0]         snd_sat;
  logic [CHANNELS-1:0]       cmd_hit;

  logic [ADDR_W-1:0] start_r [CHANNELS];
  logic [ADDR_W-1:0] ptr_r   [CHANNELS];
  logic [LEN_W-1:0]  rem_r   [CHANNELS];
  logic [LEN_W-1:0]  len_r   [CHANNELS];
  logic [7:0]        vol_r   [CHANNELS];
  logic [CHANNELS-1:0] loop_r;
  logic [CHANNELS-1:0] active_r;

  assign div_lim = (I_DIV == '0) ? DIV_W'(1) : I_DIV;
  assign tick    = (div_cnt >= div_lim - DIV_W'(1));
  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  assign prod     = $signed({{9{data_q[DATA_W-1]}}, data_q}) * $signed({{DATA_W{1'b0}}, vol_r[ch]});
  assign acc_next = acc + $signed({{CH_W{prod[DATA_W+8]}}, prod});
  assign acc_sh   = acc >>> 8;

  always_comb begin
    if (acc_sh > SAT_MAX)      snd_sat = SAT_MAX[DATA_W-1:0];
    else if (acc_sh < SAT_MIN) snd_sat = SAT_MIN[DATA_W-1:0];
    else                       snd_sat = acc_sh[DATA_W-1:0];
  end

  // A start with zero length is a no-op, so it must not mask the MAC update either.
  always_comb begin
    cmd_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      cmd_hit[i] = I_CMD_VALID && (I_CMD_CHAN == CH_W'(i)) && (!I_CMD_OP || (I_CMD_LEN != '0));
  end

  assign O_ROM_REQ  = (state == S_SCAN) && active_r[ch];
  assign O_ROM_ADDR = (state == S_SCAN) ? ptr_r[ch] : '0;
  assign O_ACTIVE   = active_r;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int i = 0; i < CHANNELS; i++) begin
        start_r[i] <= '0;
        ptr_r[i]   <= '0;
        rem_r[i]   <= '0;
        len_r[i]   <= '0;
        vol_r[i]   <= '0;
      end
      loop_r   <= '0;
      active_r <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cmd_hit[i]) begin
          if (I_CMD_OP) begin
            start_r[i]  <= I_CMD_ADDR;
            ptr_r[i]    <= I_CMD_ADDR;
            rem_r[i]    <= I_CMD_LEN;
            len_r[i]    <= I_CMD_LEN;
            vol_r[i]    <= I_CMD_VOL;
            loop_r[i]   <= I_CMD_LOOP;
            active_r[i] <= 1'b1;
          end else begin
            active_r[i] <= 1'b0;
          end
        end else if ((state == S_MAC) && (ch == CH_W'(i))) begin
          if (rem_r[i] == LEN_W'(1) && loop_r[i]) begin
            ptr_r[i] <= start_r[i];
            rem_r[i] <= len_r[i];
          end else begin
            ptr_r[i] <= ptr_r[i] + 1'b1;
            rem_r[i] <= rem_r[i] - 1'b1;
            if (rem_r[i] == LEN_W'(1)) active_r[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state         <= S_IDLE;
      ch            <= '0;
      div_cnt       <= '0;
      data_q        <= '0;
      acc           <= '0;
      O_SND         <= '0;
      O_SAMPLE_TICK <= 1'b0;
      O_OVERRUN     <= 1'b0;
    end else begin
      div_cnt       <= tick ? '0 : div_cnt + 1'b1;
      O_SAMPLE_TICK <= 1'b0;
      if (tick && (state != S_IDLE)) O_OVERRUN <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            acc   <= '0;
            ch    <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!active_r[ch]) begin
            if (last_ch) state <= S_OUT;
            else         ch    <= ch + 1'b1;
          end else if (I_ROM_ACK) begin
            data_q <= I_ROM_DATA;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (last_ch) begin
            state <= S_OUT;
          end else begin
            ch    <= ch + 1'b1;
            state <= S_SCAN;
          end
        end
        S_OUT: begin
          O_SND         <= snd_sat;
          O_SAMPLE_TICK <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wav_sample_mixer.sv
// Self-checking bench for wav_sample_mixer: ROM responder with programmable ack delay,
// expected samples/addresses queued at stimulus time and compared as the DUT produces them.
module tb_wav_sample_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] div;
  logic        cmd_valid, cmd_op, cmd_loop;
  logic [2:0]  cmd_chan;
  logic [15:0] cmd_addr, cmd_len;
  logic [7:0]  cmd_vol;
  logic        rom_req, rom_ack, sample_tick, overrun;
  logic [15:0] rom_addr, rom_data, snd;
  logic [7:0]  active;

  wav_sample_mixer dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_DIV(div),
    .I_CMD_VALID(cmd_valid), .I_CMD_CHAN(cmd_chan), .I_CMD_OP(cmd_op),
    .I_CMD_ADDR(cmd_addr), .I_CMD_LEN(cmd_len), .I_CMD_VOL(cmd_vol), .I_CMD_LOOP(cmd_loop),
    .O_ROM_REQ(rom_req), .O_ROM_ADDR(rom_addr), .I_ROM_ACK(rom_ack), .I_ROM_DATA(rom_data),
    .O_SND(snd), .O_ACTIVE(active), .O_SAMPLE_TICK(sample_tick), .O_OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [0:65535];
  int          ack_delay = 0;
  int          wcnt;
  assign rom_data = rom_mem[rom_addr];
  assign rom_ack  = rom_req && (wcnt >= ack_delay);

  always @(posedge clk or negedge rst_n)
    if (!rst_n)                wcnt <= 0;
    else if (!rom_req || rom_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;

  // Fetch log plus a sticky flag for any address change during one request.
  logic [15:0] cap_addr [0:1023];
  int          cap_n = 0;
  bit          hold_bad = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rom_req && rom_ack) begin
      cap_addr[cap_n[9:0]] <= rom_addr;
      cap_n <= cap_n + 1;
    end
    if (prev_req && rom_req && (rom_addr != prev_addr)) hold_bad <= 1'b1;
    prev_req  <= rom_req;
    prev_addr <= rom_addr;
  end

  int tests = 0, fails = 0;
  logic [15:0] exp_snd [$];
  logic [7:0]  exp_act [$];
  logic [15:0] exp_addr [$];

  task automatic cmd(input int ch, input bit op, input int addr, input int len, input int vol, input bit lp);
    cmd_valid = 1'b1; cmd_chan = 3'(ch); cmd_op = op;
    cmd_addr = 16'(addr); cmd_len = 16'(len); cmd_vol = 8'(vol); cmd_loop = lp;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sample_tick) begin ok = 1'b1; return; end
    end
    tests++; fails++;
    $display("FAIL sample_timeout: got no O_SAMPLE_TICK within 2000 cycles, required one");
  endtask

  task automatic test_reset;
    rst_n = 1'b0; div = 12'd32; cmd_valid = 1'b0; cmd_chan = '0; cmd_op = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_vol = '0; cmd_loop = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (snd !== 16'h0) begin fails++; $display("FAIL reset_snd: got %h required 0000", snd); end
    tests++; if (active !== 8'h0) begin fails++; $display("FAIL reset_active: got %h required 00", active); end
    tests++; if ({rom_req, rom_addr} !== 17'h0) begin fails++; $display("FAIL reset_rom: got req=%b addr=%h required 0/0000", rom_req, rom_addr); end
    tests++; if ({sample_tick, overrun} !== 2'b00) begin fails++; $display("FAIL reset_flags: got tick=%b ovr=%b required 0/0", sample_tick, overrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Compares the queued samples, then the queued fetch addresses from fetch index base.
  task automatic drain(input string name, input int base);
    bit ok;
    logic [15:0] e; logic [7:0] a;
    while (exp_snd.size() > 0) begin
      wait_tick(ok);
      e = exp_snd.pop_front(); a = exp_act.pop_front();
      if (!ok) return;
      tests++;
      if (snd !== e || active !== a) begin
        fails++; $display("FAIL %s_sample: got snd=%h act=%h required snd=%h act=%h", name, snd, active, e, a);
      end
    end
    @(negedge clk);
    tests++;
    if (cap_n - base != exp_addr.size()) begin
      fails++; $display("FAIL %s_fetch_count: got %0d required %0d", name, cap_n - base, exp_addr.size());
    end
    for (int k = 0; exp_addr.size() > 0; k++) begin
      e = exp_addr.pop_front();
      tests++;
      if (cap_addr[base + k] !== e) begin
        fails++; $display("FAIL %s_addr%0d: got %h required %h", name, k, cap_addr[base + k], e);
      end
    end
  endtask

  task automatic test_single;
    bit ok; int base;
    rom_mem[16'h100] = 16'h4000; rom_mem[16'h101] = 16'h4000;
    rom_mem[16'h102] = 16'h4000; rom_mem[16'h103] = 16'h4000;
    wait_tick(ok); base = cap_n;
    cmd(0, 1'b1, 'h100, 4, 255, 1'b0);
    tests++; if (active !== 8'h01) begin fails++; $display("FAIL single_active_on: got %h required 01", active); end
    for (int k = 0; k < 4; k++) begin
      exp_addr.push_back(16'(16'h100 + k));
      exp_snd.push_back(16'h3FC0);
      exp_act.push_back(k < 3 ? 8'h01 : 8'h00);
    end
    exp_snd.push_back(16'h0000); exp_act.push_back(8'h00);
    drain("single", base);
  endtask

  task automatic test_loop;
    bit ok; int base;
    wait_tick(ok); base = cap_n;
    cmd(0, 1'b1, 'h100, 2, 255, 1'b1);
    for (int k = 0; k < 6; k++) begin
      exp_addr.push_back((k % 2 == 0) ? 16'h100 : 16'h101);
      exp_snd.push_back(16'h3FC0); exp_act.push_back(8'h01);
    end
    for (int k = 0; k < 6; k++) begin
      wait_tick(ok);
      if (!ok) break;
      tests++;
      if (snd !== exp_snd[0] || active !== exp_act[0]) begin
        fails++; $display("FAIL loop_sample%0d: got snd=%h act=%h required %h/%h", k, snd, active, exp_snd[0], exp_act[0]);
      end
      void'(exp_snd.pop_front()); void'(exp_act.pop_front());
    end
    cmd(0, 1'b0, 0, 0, 0, 1'b0);
    tests++; if (active !== 8'h00) begin fails++; $display("FAIL loop_stop_active: got %h required 00", active); end
    exp_snd.delete(); exp_act.delete();
    exp_snd.push_back(16'h0000); exp_act.push_back(8'h00);
    drain("loop", base);
  endtask

  task automatic test_saturation;
    bit ok;
    logic [15:0] d [3];
    logic [15:0] want [3];
    d[0] = 16'h7000; d[1] = 16'h9000; d[2] = 16'h4000;
    want[0] = 16'h7FFF; want[1] = 16'h8000; want[2] = 16'h3FC0;
    rom_mem[16'h400] = 16'h7FFF;
    for (int p = 0; p < 3; p++) begin
      rom_mem[16'h200] = d[p]; rom_mem[16'h300] = d[p];
      wait_tick(ok);
      cmd(0, 1'b1, 'h200, 1, 255, 1'b0);
      if (p < 2) cmd(1, 1'b1, 'h300, 1, 255, 1'b0);
      cmd(2, 1'b1, 'h400, 1, 0, 1'b0);
      wait_tick(ok);
      if (!ok) return;
      tests++;
      if (snd !== want[p]) begin fails++; $display("FAIL saturation_p%0d: got %h required %h", p, snd, want[p]); end
    end
  endtask

  task automatic test_len_zero;
    bit ok;
    wait_tick(ok);
    cmd(5, 1'b1, 'h500, 3, 10, 1'b1);
    cmd(5, 1'b1, 'h600, 0, 10, 1'b0);
    tests++; if (active !== 8'h20) begin fails++; $display("FAIL len0_keep_active: got %h required 20", active); end
    cmd(6, 1'b1, 'h600, 0, 10, 1'b0);
    tests++; if (active !== 8'h20) begin fails++; $display("FAIL len0_no_start: got %h required 20", active); end
    cmd(5, 1'b0, 0, 0, 0, 1'b0);
    tests++; if (active !== 8'h00) begin fails++; $display("FAIL len0_stop: got %h required 00", active); end
  endtask

  task automatic test_wrap;
    bit ok; int base;
    rom_mem[16'hFFFF] = 16'h0100; rom_mem[16'h0000] = 16'h0200;
    wait_tick(ok); base = cap_n;
    cmd(0, 1'b1, 'hFFFF, 2, 255, 1'b0);
    exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000);
    exp_snd.push_back(16'h00FF); exp_act.push_back(8'h01);
    exp_snd.push_back(16'h01FE); exp_act.push_back(8'h00);
    drain("wrap", base);
  endtask

  task automatic test_back_to_back;
    bit ok; int base;
    longint sum, s;
    logic signed [15:0] d; int v; logic [15:0] a;
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b required 0", overrun); end
    ack_delay = 3; sum = 0;
    wait_tick(ok); base = cap_n;
    for (int i = 0; i < 8; i++) begin
      a = 16'(16'h1000 + 16 * i);
      d = 16'($urandom); v = $urandom_range(0, 255);
      rom_mem[a] = d;
      sum += longint'(d) * v;
      exp_addr.push_back(a);
      cmd(i, 1'b1, a, 1, v, 1'b0);
    end
    div = 12'd20;
    s = sum >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    exp_snd.push_back(16'(s)); exp_act.push_back(8'h00);
    exp_snd.push_back(16'h0000); exp_act.push_back(8'h00);
    drain("arb", base);
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b required 1", overrun); end
    tests++; if (hold_bad !== 1'b0) begin fails++; $display("FAIL addr_hold: got change-during-req=%b required 0", hold_bad); end
    ack_delay = 0;
  endtask

  task automatic test_div;
    bit ok; int n;
    int divs [2];
    int want [2];
    divs[0] = 0; divs[1] = 32; want[0] = 10; want[1] = 32;
    for (int p = 0; p < 2; p++) begin
      div = 12'(divs[p]);
      wait_tick(ok); wait_tick(ok);
      n = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk); n++;
        if (sample_tick) break;
      end
      tests++;
      if (n != want[p]) begin fails++; $display("FAIL div%0d_period: got %0d cycles required %0d", divs[p], n, want[p]); end
    end
  endtask

  task automatic test_reset_mid_fetch;
    bit ok, seen;
    ack_delay = 1000;
    wait_tick(ok);
    cmd(0, 1'b1, 'h100, 4, 255, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = rom_req;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL midfetch_req: got no O_ROM_REQ within 200 cycles, required one"); end
    rst_n = 1'b0;
    #1;
    tests++; if ({rom_req, rom_addr} !== 17'h0) begin fails++; $display("FAIL midfetch_rom: got req=%b addr=%h required 0/0000", rom_req, rom_addr); end
    tests++; if ({snd, active, sample_tick, overrun} !== 26'h0) begin fails++; $display("FAIL midfetch_outs: got snd=%h act=%h tick=%b ovr=%b required all 0", snd, active, sample_tick, overrun); end
    @(negedge clk);
    rst_n = 1'b1; ack_delay = 0;
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (rom_req) seen = 1'b1; end
    tests++; if (seen || active !== 8'h00) begin fails++; $display("FAIL midfetch_after: got req_seen=%b act=%h required 0/00", seen, active); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = '0;
    test_reset;
    test_single;
    test_loop;
    test_saturation;
    test_len_zero;
    test_wrap;
    test_back_to_back;
    test_div;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
